// File: rtl/multicore_dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port among N_CORES cores, with a read-tag
// pipeline that routes returning data and a run FSM that tracks core activity.
module multicore_dram_arbiter #(
  parameter int N_CORES = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic [N_CORES-1:0]          o_core_start,
  input  logic [N_CORES-1:0]          i_core_busy,
  input  logic [N_CORES-1:0]          i_core_read,
  input  logic [N_CORES-1:0]          i_core_write,
  input  logic [N_CORES*ADDR_W-1:0]   i_core_addr,
  input  logic [N_CORES*DATA_W-1:0]   i_core_wdata,
  output logic [N_CORES-1:0]          o_core_grant,
  output logic [N_CORES-1:0]          o_core_rvalid,
  output logic [DATA_W-1:0]           o_core_rdata,
  output logic [ADDR_W-1:0]           o_dram_addr,
  output logic [DATA_W-1:0]           o_dram_wdata,
  output logic                        o_dram_read,
  output logic                        o_dram_write,
  input  logic [DATA_W-1:0]           i_dram_rdata
);

  localparam int PTR_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int REQ_PAD = 1 << PTR_W;

  typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;

  state_t                          r_state;
  logic                            r_busy;
  logic [N_CORES-1:0]              r_coreStart;
  logic [PTR_W-1:0]                r_ptr;
  logic [RD_LAT-1:0]               r_tagValid;
  logic [RD_LAT-1:0][PTR_W-1:0]    r_tagIdx;

  logic [N_CORES-1:0]              w_req;
  logic [REQ_PAD-1:0]              w_reqPad;
  logic                            w_grantValid;
  logic [PTR_W-1:0]                w_grantIdx;
  logic [PTR_W-1:0]                w_ptrNext;
  logic [N_CORES-1:0]              w_grantOneHot;
  logic [N_CORES-1:0]              w_rvalidOneHot;
  logic [ADDR_W-1:0]               w_dramAddr;
  logic [DATA_W-1:0]               w_dramWdata;
  logic                            w_grantRead;
  logic                            w_grantWrite;
  logic                            w_outstanding;

  assign w_req = i_core_read | i_core_write;

  // Walk candidates from the pointer, wrapping at N_CORES-1; grants are masked in reset.
  always_comb begin
    logic [PTR_W-1:0] cand;
    w_reqPad               = '0;
    w_reqPad[N_CORES-1:0]  = w_req;
    w_grantValid           = 1'b0;
    w_grantIdx             = '0;
    cand                   = r_ptr;
    for (int i = 0; i < N_CORES; i++) begin
      if (!w_grantValid && w_reqPad[cand]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = cand;
      end
      cand = (cand == PTR_W'(N_CORES - 1)) ? '0 : cand + PTR_W'(1);
    end
    if (!i_rst_n) w_grantValid = 1'b0;
  end

  // Read+write together from one core is issued as a write only.
  always_comb begin
    w_grantOneHot = '0;
    w_dramAddr    = '0;
    w_dramWdata   = '0;
    w_grantRead   = 1'b0;
    w_grantWrite  = 1'b0;
    for (int k = 0; k < N_CORES; k++) begin
      if (w_grantValid && (w_grantIdx == PTR_W'(k))) begin
        w_grantOneHot[k] = 1'b1;
        w_dramAddr       = i_core_addr[k*ADDR_W +: ADDR_W];
        w_dramWdata      = i_core_wdata[k*DATA_W +: DATA_W];
        w_grantWrite     = i_core_write[k];
        w_grantRead      = i_core_read[k] & ~i_core_write[k];
      end
    end
  end

  always_comb begin
    w_rvalidOneHot = '0;
    for (int k = 0; k < N_CORES; k++) begin
      w_rvalidOneHot[k] = r_tagValid[RD_LAT-1] && (r_tagIdx[RD_LAT-1] == PTR_W'(k));
    end
  end

  assign w_ptrNext     = (w_grantIdx == PTR_W'(N_CORES - 1)) ? '0 : w_grantIdx + PTR_W'(1);
  assign w_outstanding = (|r_tagValid) | w_grantRead;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr      <= '0;
      r_tagValid <= '0;
      r_tagIdx   <= '0;
    end else begin
      if (w_grantValid) r_ptr <= w_ptrNext;
      r_tagValid[0] <= w_grantRead;
      r_tagIdx[0]   <= w_grantIdx;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagIdx[i]   <= r_tagIdx[i-1];
      end
    end
  end

  // Busy is held through DRAIN until every issued read has returned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_coreStart <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_coreStart <= '0;
          if (i_start) begin
            r_state     <= START;
            r_busy      <= 1'b1;
            r_coreStart <= '1;
          end
        end
        START: begin
          r_state     <= RUN;
          r_coreStart <= '0;
        end
        RUN: begin
          if (i_core_busy == '0) r_state <= DRAIN;
        end
        DRAIN: begin
          if (|i_core_busy) begin
            r_state <= RUN;
          end else if (!w_outstanding) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_coreStart <= '0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_core_start  = r_coreStart;
  assign o_core_grant  = w_grantOneHot;
  assign o_core_rvalid = w_rvalidOneHot;
  assign o_core_rdata  = i_dram_rdata;
  assign o_dram_addr   = w_dramAddr;
  assign o_dram_wdata  = w_dramWdata;
  assign o_dram_read   = w_grantRead;
  assign o_dram_write  = w_grantWrite;

endmodule

// File: tb/tb_multicore_dram_arbiter.sv
// Directed bench for multicore_dram_arbiter: three instances cover the
// 2-core/latency-1, 3-core/latency-3 and 3-core/latency-2 configurations.
`timescale 1ns/1ps
module tb_multicore_dram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: N_CORES=2, RD_LAT=1
  logic        a_start;
  logic        a_busy;
  logic [1:0]  a_core_start, a_core_busy, a_read, a_write, a_grant, a_rvalid;
  logic [31:0] a_addr;
  logic [15:0] a_wdata;
  logic [7:0]  a_rdata, a_dram_wdata, a_dq;
  logic [15:0] a_dram_addr;
  logic        a_dram_read, a_dram_write;

  // Instance B: N_CORES=3, RD_LAT=3
  logic        b_start;
  logic        b_busy;
  logic [2:0]  b_core_start, b_core_busy, b_read, b_write, b_grant, b_rvalid;
  logic [47:0] b_addr;
  logic [23:0] b_wdata;
  logic [7:0]  b_rdata, b_dram_wdata, b_dq;
  logic [15:0] b_dram_addr;
  logic        b_dram_read, b_dram_write;

  // Instance C: N_CORES=3, RD_LAT=2
  logic        c_start;
  logic        c_busy;
  logic [2:0]  c_core_start, c_core_busy, c_read, c_write, c_grant, c_rvalid;
  logic [47:0] c_addr;
  logic [23:0] c_wdata;
  logic [7:0]  c_rdata, c_dram_wdata, c_dq;
  logic [15:0] c_dram_addr;
  logic        c_dram_read, c_dram_write;

  multicore_dram_arbiter #(.N_CORES(2), .ADDR_W(16), .DATA_W(8), .RD_LAT(1)) dutA (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .o_busy(a_busy),
    .o_core_start(a_core_start), .i_core_busy(a_core_busy),
    .i_core_read(a_read), .i_core_write(a_write), .i_core_addr(a_addr),
    .i_core_wdata(a_wdata), .o_core_grant(a_grant), .o_core_rvalid(a_rvalid),
    .o_core_rdata(a_rdata), .o_dram_addr(a_dram_addr), .o_dram_wdata(a_dram_wdata),
    .o_dram_read(a_dram_read), .o_dram_write(a_dram_write), .i_dram_rdata(a_dq)
  );

  multicore_dram_arbiter #(.N_CORES(3), .ADDR_W(16), .DATA_W(8), .RD_LAT(3)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .o_busy(b_busy),
    .o_core_start(b_core_start), .i_core_busy(b_core_busy),
    .i_core_read(b_read), .i_core_write(b_write), .i_core_addr(b_addr),
    .i_core_wdata(b_wdata), .o_core_grant(b_grant), .o_core_rvalid(b_rvalid),
    .o_core_rdata(b_rdata), .o_dram_addr(b_dram_addr), .o_dram_wdata(b_dram_wdata),
    .o_dram_read(b_dram_read), .o_dram_write(b_dram_write), .i_dram_rdata(b_dq)
  );

  multicore_dram_arbiter #(.N_CORES(3), .ADDR_W(16), .DATA_W(8), .RD_LAT(2)) dutC (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(c_start), .o_busy(c_busy),
    .o_core_start(c_core_start), .i_core_busy(c_core_busy),
    .i_core_read(c_read), .i_core_write(c_write), .i_core_addr(c_addr),
    .i_core_wdata(c_wdata), .o_core_grant(c_grant), .o_core_rvalid(c_rvalid),
    .o_core_rdata(c_rdata), .o_dram_addr(c_dram_addr), .o_dram_wdata(c_dram_wdata),
    .o_dram_read(c_dram_read), .o_dram_write(c_dram_write), .i_dram_rdata(c_dq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr,
                               input logic [31:0] addr, input logic [15:0] wd);
    a_read  = rd;
    a_write = wr;
    a_addr  = addr;
    a_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_core_busy = '0; a_dq = '0;
    b_start = 0; b_core_busy = '0; b_read = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_dq = '0;
    c_start = 0; c_core_busy = '0; c_read = '0; c_write = '0; c_addr = '0; c_wdata = '0; c_dq = '0;
    applyStimulus(2'b11, 2'b00, 32'hABCD_1234, 16'hFFFF);
    #2;
    checkOutput("rst_grant",     32'(a_grant),     32'h0);
    checkOutput("rst_dram_read", 32'(a_dram_read), 32'h0);
    checkOutput("rst_dram_addr", 32'(a_dram_addr), 32'h0);
    checkOutput("rst_rvalid",    32'(a_rvalid),    32'h0);
    checkOutput("rst_busy",      32'(b_busy),      32'h0);
    checkOutput("rst_core_start",32'(b_core_start),32'h0);
    applyStimulus(2'b00, 2'b00, 32'h0, 16'h0);
    #10 rst_n = 1'b1;

    // Single read from core 0 with latency 1
    tick();
    applyStimulus(2'b01, 2'b00, 32'h0000_0010, 16'h0);
    a_dq = 8'h5A;
    @(negedge clk);
    checkOutput("rd_grant",     32'(a_grant),     32'h1);
    checkOutput("rd_dram_read", 32'(a_dram_read), 32'h1);
    checkOutput("rd_dram_addr", 32'(a_dram_addr), 32'h0010);
    checkOutput("rd_rvalid_early", 32'(a_rvalid), 32'h0);
    tick();
    applyStimulus(2'b00, 2'b00, 32'h0, 16'h0);
    @(negedge clk);
    checkOutput("rd_rvalid", 32'(a_rvalid), 32'h1);
    checkOutput("rd_rdata",  32'(a_rdata),  32'h5A);
    checkOutput("rd_idle_grant", 32'(a_grant), 32'h0);

    // Core 1 read+write collapses to write only
    tick();
    applyStimulus(2'b10, 2'b10, {16'h1234, 16'h0000}, {8'hC3, 8'h00});
    @(negedge clk);
    checkOutput("wr_grant",      32'(a_grant),      32'h2);
    checkOutput("wr_dram_write", 32'(a_dram_write), 32'h1);
    checkOutput("wr_dram_read",  32'(a_dram_read),  32'h0);
    checkOutput("wr_dram_addr",  32'(a_dram_addr),  32'h1234);
    checkOutput("wr_dram_wdata", 32'(a_dram_wdata), 32'hC3);
    tick();
    applyStimulus(2'b00, 2'b00, {16'h1234, 16'h5555}, {8'hC3, 8'h77});
    @(negedge clk);
    checkOutput("wr_no_rvalid", 32'(a_rvalid),     32'h0);
    checkOutput("idle_addr",    32'(a_dram_addr),  32'h0);
    checkOutput("idle_wdata",   32'(a_dram_wdata), 32'h0);

    // Contention on A: pointer is back at 0, so core 0 then core 1
    tick();
    applyStimulus(2'b11, 2'b00, {16'h0222, 16'h0111}, 16'h0);
    @(negedge clk);
    checkOutput("cont_grant0", 32'(a_grant), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("cont_grant1", 32'(a_grant),     32'h2);
    checkOutput("cont_addr1",  32'(a_dram_addr), 32'h0222);
    checkOutput("cont_rvalid0",32'(a_rvalid),    32'h1);
    tick();
    applyStimulus(2'b00, 2'b00, 32'h0, 16'h0);
    @(negedge clk);
    checkOutput("cont_rvalid1", 32'(a_rvalid), 32'h2);

    // Continuous reads from all three cores on C (latency 2)
    for (int j = 0; j < 8; j++) begin
      logic [2:0] expGrant;
      logic [2:0] expRvalid;
      tick();
      c_read = (j < 6) ? 3'b111 : 3'b000;
      expGrant  = (j < 6) ? 3'(1 << (j % 3)) : 3'b000;
      expRvalid = (j >= 2) ? 3'(1 << ((j - 2) % 3)) : 3'b000;
      @(negedge clk);
      checkOutput($sformatf("rr_grant_%0d", j),  32'(c_grant),  32'(expGrant));
      checkOutput($sformatf("rr_rvalid_%0d", j), 32'(c_rvalid), 32'(expRvalid));
    end

    // Run FSM on B (latency 3)
    tick();
    b_start = 1'b1;
    @(negedge clk);
    checkOutput("fsm_idle_busy", 32'(b_busy), 32'h0);
    tick();
    b_start = 1'b0;
    @(negedge clk);
    checkOutput("fsm_start_pulse", 32'(b_core_start), 32'h7);
    checkOutput("fsm_start_busy",  32'(b_busy),       32'h1);
    b_addr = {16'h0, 16'h0, 16'h0040};
    b_dq   = 8'h77;
    for (int k = 1; k <= 5; k++) begin
      tick();
      b_core_busy = 3'b111;
      b_start     = (k == 1);
      b_read      = (k == 5) ? 3'b001 : 3'b000;
      @(negedge clk);
      checkOutput($sformatf("fsm_run_start_%0d", k), 32'(b_core_start), 32'h0);
      checkOutput($sformatf("fsm_run_busy_%0d", k),  32'(b_busy),       32'h1);
      if (k == 5) checkOutput("fsm_last_grant", 32'(b_grant), 32'h1);
    end
    for (int k = 6; k <= 10; k++) begin
      tick();
      b_core_busy = 3'b000;
      b_read      = 3'b000;
      b_start     = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("fsm_drain_busy_%0d", k),   32'(b_busy),   (k < 10) ? 32'h1 : 32'h0);
      checkOutput($sformatf("fsm_drain_rvalid_%0d", k), 32'(b_rvalid), (k == 8) ? 32'h1 : 32'h0);
      checkOutput($sformatf("fsm_drain_start_%0d", k),  32'(b_core_start), 32'h0);
      if (k == 8) checkOutput("fsm_rdata", 32'(b_rdata), 32'h77);
    end

    // Reset while a read is outstanding on C (latency 2)
    c_addr = {16'h3333, 16'h2222, 16'h1111};
    tick();
    c_read = 3'b010;
    @(negedge clk);
    checkOutput("rr_mid_grant", 32'(c_grant), 32'h2);
    tick();
    c_read = 3'b001;
    rst_n  = 1'b0;
    #1;
    checkOutput("mid_rst_grant",     32'(c_grant),     32'h0);
    checkOutput("mid_rst_rvalid",    32'(c_rvalid),    32'h0);
    checkOutput("mid_rst_dram_read", 32'(c_dram_read), 32'h0);
    checkOutput("mid_rst_dram_addr", 32'(c_dram_addr), 32'h0);
    tick();
    rst_n  = 1'b1;
    c_read = 3'b111;
    @(negedge clk);
    checkOutput("post_rst_ptr",    32'(c_grant),  32'h1);
    checkOutput("post_rst_rvalid0",32'(c_rvalid), 32'h0);
    tick();
    c_read = 3'b000;
    @(negedge clk);
    checkOutput("post_rst_rvalid1", 32'(c_rvalid), 32'h0);
    tick();
    @(negedge clk);
    checkOutput("post_rst_rvalid2", 32'(c_rvalid), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("post_rst_rvalid3", 32'(c_rvalid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
